addsub_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 8-bit adder/subtractor datapath among four requesters. Each requester presents two operands and a mode bit and holds them under a req/ack handshake. The block grants one requester at a time, latches its operands, and performs the add or subtract in a registered execute step. It then returns the 8-bit result with carry and signed-overflow flags. It sits between independent control FSMs and the shared arithmetic datapath, replacing per-FSM adder copies.

---
 rtl/addsub_arbiter.sv | 119 +++++++++++
 tb/tb_addsub_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_arbiter.sv
// addsub_arbiter: four requesters share one 8-bit add/subtract datapath.
// A round-robin pick in IDLE selects a requester; its operands are latched in
// LOAD, the arithmetic is registered in EXEC and DONE pulses the matching ack.
module addsub_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [3:0]  sub,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic [3:0]  gnt,
    output logic [3:0]  ack,
    output logic [7:0]  result,
    output logic        cout,
    output logic        ovf,
    output logic        busy
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StExec,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  a_q, b_q;
    logic        m_q;
    logic [1:0]  sel_q;
    logic [1:0]  ptr_q;
    logic [7:0]  result_q;
    logic        cout_q;
    logic        ovf_q;

    logic [1:0]  pick;
    logic        pick_valid;
    logic [1:0]  idx;
    logic [7:0]  b_x;
    logic [8:0]  sum;
    logic [3:0]  sel_oh;

    // Round-robin search starting at ptr; the first hit in ptr..ptr+3 wins.
    always_comb begin
        pick       = ptr_q;
        pick_valid = 1'b0;
        idx        = ptr_q;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!pick_valid && req[idx]) begin
                pick       = idx;
                pick_valid = 1'b1;
            end
        end
    end

    // Shared datapath: subtract is A + ~B + 1, so cout=1 means no borrow.
    always_comb begin
        b_x = b_q ^ {8{m_q}};
        sum = {1'b0, a_q} + {1'b0, b_x} + {8'b0, m_q};
    end

    // Next-state sequencing; req is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (pick_valid) state_d = StLoad;
            StLoad: state_d = StExec;
            StExec: state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            m_q      <= 1'b0;
            sel_q    <= 2'd0;
            ptr_q    <= 2'd0;
            result_q <= 8'h00;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && pick_valid) begin
                sel_q <= pick;
            end
            if (state_q == StLoad) begin
                a_q <= opa[{sel_q, 3'b000} +: 8];
                b_q <= opb[{sel_q, 3'b000} +: 8];
                m_q <= sub[sel_q];
            end
            if (state_q == StExec) begin
                result_q <= sum[7:0];
                cout_q   <= sum[8];
                ovf_q    <= (a_q[7] == b_x[7]) && (sum[7] != a_q[7]);
            end
            if (state_q == StDone) begin
                // Served requester drops to lowest priority next time round.
                ptr_q <= sel_q + 2'd1;
            end
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        sel_oh = 4'b0001 << sel_q;
        busy   = (state_q != StIdle);
        gnt    = busy ? sel_oh : 4'b0000;
        ack    = (state_q == StDone) ? sel_oh : 4'b0000;
        result = result_q;
        cout   = cout_q;
        ovf    = ovf_q;
    end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter with a queue of expected completions.
module tb_addsub_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  sub;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [7:0]  result;
    logic        cout;
    logic        ovf;
    logic        busy;

    typedef struct {
        logic [3:0] ack;
        logic [7:0] res;
        logic       c;
        logic       v;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b0;

    addsub_arbiter dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .sub    (sub),
        .opa    (opa),
        .opb    (opb),
        .gnt    (gnt),
        .ack    (ack),
        .result (result),
        .cout   (cout),
        .ovf    (ovf),
        .busy   (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference arithmetic written with integer ranges rather than bit tricks.
    function automatic exp_t model(input int k, input bit s, input logic [7:0] a,
                                   input logic [7:0] b);
        exp_t e;
        int   ua = int'(a);
        int   ub = int'(b);
        int   sa = int'($signed(a));
        int   sb = int'($signed(b));
        int   sr;
        int   ur;
        if (s) begin
            sr  = sa - sb;
            ur  = ua - ub;
            e.c = (ua >= ub);
        end else begin
            sr  = sa + sb;
            ur  = ua + ub;
            e.c = (ur > 255);
        end
        e.res = 8'(ur & 255);
        e.v   = (sr > 127) || (sr < -128);
        e.ack = 4'b0001 << k;
        return e;
    endfunction

    task automatic drive(input int k, input bit s, input logic [7:0] a, input logic [7:0] b);
        sub[k]           = s;
        opa[k*8 +: 8]    = a;
        opb[k*8 +: 8]    = b;
    endtask

    task automatic expect_op(input int k, input bit s, input logic [7:0] a,
                             input logic [7:0] b);
        exp_q.push_back(model(k, s, a, b));
    endtask

    // Single isolated request from IDLE: ack must arrive exactly 3 cycles later.
    task automatic run_op(input int k, input bit s, input logic [7:0] a, input logic [7:0] b);
        int cnt = 0;
        drive(k, s, a, b);
        expect_op(k, s, a, b);
        req[k] = 1'b1;
        do begin
            @(negedge clk);
            cnt++;
        end while (ack[k] !== 1'b1 && cnt < 20);
        check("latency", cnt, 3);
        req[k] = 1'b0;
        @(negedge clk);
    endtask

    // Wait for n completions from a held request set; they must be 4 cycles apart.
    task automatic wait_n_acks(input int n);
        int got  = 0;
        int cyc  = 0;
        int last = -1;
        while (got < n && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (ack !== 4'b0000) begin
                if (last < 0) check("first_latency", cyc, 3);
                else          check("ack_gap", cyc - last, 4);
                last = cyc;
                got++;
            end
        end
        check("ack_count", got, n);
    endtask

    // Scoreboard side: every ack pops one expected completion.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            check("gnt_onehot0", 32'($onehot0(gnt)), 1);
            check("ack_onehot0", 32'($onehot0(ack)), 1);
            if (ack !== 4'b0000) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", ack, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_id", ack, e.ack);
                    check("result", result, e.res);
                    check("cout", cout, e.c);
                    check("ovf", ovf, e.v);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        req   = 4'b0000;
        sub   = 4'b0000;
        opa   = 32'h0;
        opb   = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_gnt", gnt, 0);
        check("rst_ack", ack, 0);
        check("rst_result", result, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        check("rst_busy", busy, 0);
        mon_en = 1'b1;
        @(negedge clk);

        // 0x7F + 0x01 on requester 0, cycle by cycle.
        drive(0, 1'b0, 8'h7F, 8'h01);
        expect_op(0, 1'b0, 8'h7F, 8'h01);
        req = 4'b0001;
        @(negedge clk);
        check("c1_gnt", gnt, 4'b0001);
        check("c1_ack", ack, 4'b0000);
        check("c1_busy", busy, 1);
        @(negedge clk);
        check("c2_gnt", gnt, 4'b0001);
        check("c2_ack", ack, 4'b0000);
        @(negedge clk);
        check("c3_gnt", gnt, 4'b0001);
        check("c3_ack", ack, 4'b0001);
        check("c3_result", result, 8'h80);
        check("c3_cout", cout, 0);
        check("c3_ovf", ovf, 1);
        req = 4'b0000;
        @(negedge clk);
        check("c4_gnt", gnt, 4'b0000);
        check("c4_ack", ack, 4'b0000);
        check("c4_busy", busy, 0);

        // Subtract cases on requester 2 (ptr ends at 3).
        run_op(2, 1'b1, 8'h05, 8'h07);
        run_op(2, 1'b1, 8'h10, 8'h10);
        run_op(2, 1'b1, 8'h80, 8'h01);

        // Serve 3 (ptr wraps to 0), then 1 (ptr -> 2).
        run_op(3, 1'b0, 8'h40, 8'h40);
        run_op(1, 1'b0, 8'hFF, 8'h01);

        // req=0011 with ptr=2: search wraps, 0 first then 1.
        drive(0, 1'b0, 8'h0A, 8'h05);
        drive(1, 1'b1, 8'h05, 8'h0A);
        expect_op(0, 1'b0, 8'h0A, 8'h05);
        expect_op(1, 1'b1, 8'h05, 8'h0A);
        req = 4'b0011;
        wait_n_acks(2);
        req = 4'b0000;
        @(negedge clk);

        // Serve 3 again so ptr returns to 0 before the all-request run.
        run_op(3, 1'b1, 8'h7F, 8'hFF);

        // All four held: order 0,1,2,3,0.
        drive(0, 1'b0, 8'h01, 8'h02);
        drive(1, 1'b1, 8'h90, 8'h10);
        drive(2, 1'b0, 8'hC0, 8'hC0);
        drive(3, 1'b1, 8'h7F, 8'hFF);
        expect_op(0, 1'b0, 8'h01, 8'h02);
        expect_op(1, 1'b1, 8'h90, 8'h10);
        expect_op(2, 1'b0, 8'hC0, 8'hC0);
        expect_op(3, 1'b1, 8'h7F, 8'hFF);
        expect_op(0, 1'b0, 8'h01, 8'h02);
        req = 4'b1111;
        wait_n_acks(5);
        req = 4'b0000;
        @(negedge clk);

        // Requester 0 drops req during LOAD; operation still completes.
        drive(0, 1'b0, 8'h33, 8'h44);
        expect_op(0, 1'b0, 8'h33, 8'h44);
        req = 4'b0001;
        @(negedge clk);
        check("drop_load_gnt", gnt, 4'b0001);
        req = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        check("drop_ack", ack, 4'b0001);
        check("drop_result", result, 8'h77);
        @(negedge clk);

        // Reset during EXEC aborts without an ack.
        drive(2, 1'b1, 8'h20, 8'h10);
        req = 4'b0100;
        @(negedge clk);
        check("abort_load_gnt", gnt, 4'b0100);
        @(negedge clk);
        check("abort_exec_gnt", gnt, 4'b0100);
        reset = 1'b1;
        req   = 4'b0000;
        @(negedge clk);
        check("abort_gnt", gnt, 0);
        check("abort_ack", ack, 0);
        check("abort_busy", busy, 0);
        check("abort_result", result, 0);
        check("abort_cout", cout, 0);
        check("abort_ovf", ovf, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // ptr back at 0: requester 0 wins over 3.
        drive(0, 1'b0, 8'h11, 8'h22);
        drive(3, 1'b1, 8'h01, 8'h02);
        expect_op(0, 1'b0, 8'h11, 8'h22);
        expect_op(3, 1'b1, 8'h01, 8'h02);
        req = 4'b1001;
        wait_n_acks(2);
        req = 4'b0000;
        repeat (3) @(negedge clk);

        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
